dsc_sng4: RTL and testbench

//  Downstream stage of the 4-input compare-and-swap sorter. It captures the four sorted
//  SNG_WIDTH-bit values (a >= b >= c >= d) in one ready/valid handshake. It then emits them
//  as four deterministic unary bitstreams, 2**SNG_WIDTH beats long, with ready/valid flow

---
 rtl/dsc_pkg.sv | 17 +
 rtl/dsc_sng_lane.sv | 12 +
 rtl/dsc_sng4.sv | 106 ++++++++++
 tb/tb_dsc_sng4.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dsc_pkg.sv
// Shared constants and state encoding for the DSC stochastic-number generator stage.
package dsc_pkg;

  localparam int SNG_WIDTH = 6;
  localparam int NUM_LANES = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Number of beats in one stream for a given value width.
  function automatic int stream_len(input int width);
    return 1 << width;
  endfunction

endpackage

// File: rtl/dsc_sng_lane.sv
// One unary-stream lane: the bit is high while the beat counter is below the value.
module dsc_sng_lane #(
  parameter int SNG_WIDTH = 6
) (
  input  logic [SNG_WIDTH-1:0] cnt,
  input  logic [SNG_WIDTH-1:0] val,
  output logic                 bit_o
);

  assign bit_o = (cnt < val);

endmodule

// File: rtl/dsc_sng4.sv
// Captures a sorted 4-value set and replays it as four front-loaded unary bitstreams
// of 2**SNG_WIDTH beats with ready/valid flow control.
module dsc_sng4 #(
  parameter int SNG_WIDTH = dsc_pkg::SNG_WIDTH,
  parameter int NUM_LANES = dsc_pkg::NUM_LANES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SNG_WIDTH-1:0] a,
  input  logic [SNG_WIDTH-1:0] b,
  input  logic [SNG_WIDTH-1:0] c,
  input  logic [SNG_WIDTH-1:0] d,
  output logic                 bs_valid,
  input  logic                 out_ready,
  output logic [3:0]           bs,
  output logic                 bs_last,
  output logic                 sort_err
);

  import dsc_pkg::*;

  // Handshake: a transfer occurs on a rising clk edge where valid & ready are both high;
  // valid never depends on ready, while in_ready depends combinationally on out_ready.

  if (NUM_LANES != 4) begin : g_lane_check
    $error("dsc_sng4 supports exactly 4 lanes");
  end

  localparam logic [SNG_WIDTH-1:0] CNT_MAX = SNG_WIDTH'(stream_len(SNG_WIDTH) - 1);

  state_e                     state_q, state_d;
  logic [SNG_WIDTH-1:0]       cnt_q, cnt_d;
  logic [3:0][SNG_WIDTH-1:0]  val_q, val_d;
  logic                       sort_err_q, sort_err_d;

  logic [3:0][SNG_WIDTH-1:0]  in_vals;
  logic [3:0]                 lane_bits;
  logic                       run;
  logic                       last;
  logic                       capture;

  assign in_vals = {a, b, c, d};
  assign run     = (state_q == RUN);
  assign last    = run && (cnt_q == CNT_MAX);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    val_d      = val_q;
    sort_err_d = sort_err_q;
    in_ready   = !run || (last && out_ready);
    capture    = in_valid && in_ready;

    case (state_q)
      IDLE: ;
      RUN: begin
        if (out_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A capture on the final transfer overrides the return to IDLE, so there is no bubble.
    if (capture) begin
      val_d      = in_vals;
      cnt_d      = '0;
      sort_err_d = !((a >= b) && (b >= c) && (c >= d));
      state_d    = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      val_q      <= '0;
      sort_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      val_q      <= val_d;
      sort_err_q <= sort_err_d;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    dsc_sng_lane #(
      .SNG_WIDTH(SNG_WIDTH)
    ) u_lane (
      .cnt  (cnt_q),
      .val  (val_q[i]),
      .bit_o(lane_bits[i])
    );
  end

  // Lanes are masked outside RUN so stale values never leak onto bs in IDLE.
  assign bs       = lane_bits & {4{run}};
  assign bs_valid = run;
  assign bs_last  = last;
  assign sort_err = sort_err_q;

endmodule

// File: tb/tb_dsc_sng4.sv
// Randomized bench for dsc_sng4 with a beat-level reference model and ones-count scoreboard.
module tb_dsc_sng4;

  localparam int W = 6;
  localparam int L = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b, c, d;
  logic         bs_valid;
  logic         out_ready;
  logic [3:0]   bs;
  logic         bs_last;
  logic         sort_err;

  int n_chk  = 0;
  int n_fail = 0;
  int ready_pct = 100;

  logic [W-1:0] exp_q[$];

  dsc_sng4 #(.SNG_WIDTH(W), .NUM_LANES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .bs_valid (bs_valid),
    .out_ready(out_ready),
    .bs       (bs),
    .bs_last  (bs_last),
    .sort_err (sort_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Beat k of a stream for value v is 1 when k < v; the stream is L transfers long.
  bit                  m_run = 1'b0;
  int                  m_k   = 0;
  bit                  m_err = 1'b0;
  logic [3:0][W-1:0]   m_vals;
  int                  ones[4];

  always @(negedge clk or negedge rst_n) begin
    logic [3:0] exp_bs;
    bit         exp_ready;
    if (!rst_n) begin
      m_run = 1'b0;
      m_k   = 0;
      m_err = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 4; i++) ones[i] = 0;
    end else begin
      exp_ready = !m_run || (m_k == L - 1 && out_ready);
      exp_bs    = 4'b0;
      if (m_run)
        for (int i = 0; i < 4; i++) exp_bs[i] = (m_k < int'(m_vals[i]));
      check_eq("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
      check_eq("bs_valid", {31'b0, bs_valid}, {31'b0, m_run});
      check_eq("bs", {28'b0, bs}, {28'b0, exp_bs});
      check_eq("bs_last", {31'b0, bs_last}, {31'b0, (m_run && m_k == L - 1)});
      check_eq("sort_err", {31'b0, sort_err}, {31'b0, m_err});
      if (m_run && !m_err)
        check_eq("thermo", {31'b0, (bs[3] >= bs[2] && bs[2] >= bs[1] && bs[1] >= bs[0])}, 32'd1);
      if (m_run && out_ready) begin
        for (int i = 0; i < 4; i++) ones[i] += int'(bs[i]);
        m_k++;
        if (m_k == L) begin
          for (int i = 3; i >= 0; i--) check_eq("ones_count", ones[i], {26'b0, exp_q.pop_front()});
          m_run = 1'b0;
          m_k   = 0;
        end
      end
      if (in_valid && exp_ready) begin
        m_vals = {a, b, c, d};
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
        m_err = !(a >= b && b >= c && c >= d);
        m_k   = 0;
        m_run = 1'b1;
        for (int i = 0; i < 4; i++) ones[i] = 0;
      end
    end
  end

  // ---------------- driver ----------------
  always @(posedge clk) begin
    #1;
    out_ready = ($urandom_range(0, 99) < ready_pct);
  end

  task automatic send_set(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [W-1:0] vc, input logic [W-1:0] vd);
    int n   = 0;
    bit got = 1'b0;
    in_valid = 1'b1;
    a = va; b = vb; c = vc; d = vd;
    while (!got && n < 2000) begin
      @(negedge clk);
      got = in_ready;
      n++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!got) check_eq("capture_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bs_valid && n < 5000);
    if (bs_valid) check_eq("idle_timeout", 32'd0, 32'd1);
    check_eq("idle_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_random(input bit sorted);
    int v[4];
    int t;
    for (int i = 0; i < 4; i++) v[i] = $urandom_range(0, L - 1);
    if (sorted)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3 - i; j++)
          if (v[j] < v[j+1]) begin
            t = v[j]; v[j] = v[j+1]; v[j+1] = t;
          end
    send_set(W'(v[0]), W'(v[1]), W'(v[2]), W'(v[3]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    #1;
    check_eq("rst_bs_valid", {31'b0, bs_valid}, 32'd0);
    check_eq("rst_bs", {28'b0, bs}, 32'd0);
    check_eq("rst_bs_last", {31'b0, bs_last}, 32'd0);
    check_eq("rst_sort_err", {31'b0, sort_err}, 32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Evenly spaced values, no stalls
    ready_pct = 100;
    send_set(6'd48, 6'd32, 6'd16, 6'd0);
    wait_idle();

    // Extremes: L-1 and 1 and 0
    send_set(6'd63, 6'd63, 6'd1, 6'd0);
    wait_idle();

    // Random stalls
    ready_pct = 50;
    send_set(6'd40, 6'd20, 6'd10, 6'd5);
    wait_idle();

    // Back-to-back capture on the last transfer
    ready_pct = 100;
    send_set(6'd30, 6'd20, 6'd10, 6'd2);
    send_set(6'd60, 6'd45, 6'd7, 6'd1);
    wait_idle();
    ready_pct = 60;
    send_set(6'd11, 6'd11, 6'd11, 6'd11);
    send_set(6'd62, 6'd33, 6'd3, 6'd0);
    wait_idle();

    // Unsorted set, then a sorted set clears the error
    ready_pct = 100;
    send_set(6'd5, 6'd9, 6'd3, 6'd3);
    wait_idle();
    send_set(6'd9, 6'd5, 6'd3, 6'd3);
    wait_idle();

    // Reset in the middle of a stream
    send_set(6'd50, 6'd40, 6'd30, 6'd20);
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_bs_valid", {31'b0, bs_valid}, 32'd0);
    check_eq("async_bs", {28'b0, bs}, 32'd0);
    check_eq("async_bs_last", {31'b0, bs_last}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check_eq("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check_eq("post_rst_bs_valid", {31'b0, bs_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Randomized sets, stalls and back-to-back overlap
    for (int r = 0; r < 14; r++) begin
      ready_pct = ($urandom_range(0, 2) == 0) ? 100 : $urandom_range(25, 90);
      send_random($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 1) == 0) wait_idle();
    end
    wait_idle();

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
